// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder
interface pipe_adder_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         c_out;
  logic         ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined add/sub, one SEG-bit carry segment per stage; optional clamp via PIPE_ADDER_SAT_EN
module pipe_adder #(
  parameter int N   = 32,
  parameter int SEG = 8
) (
  input logic          clk,
  input logic          rstn,
  pipe_adder_if.slave  bus
);
  localparam int P = N / SEG;

  // Stage registers: operands skew forward unchanged, s_q accumulates finished segments
  logic [N-1:0] a_q [P];
  logic [N-1:0] b_q [P];
  logic [N-1:0] s_q [P];
  logic         c_q [P];
  logic         m_q [P];
  logic         v_q [P];

  logic [N-1:0] in_a [P];
  logic [N-1:0] in_b [P];
  logic [N-1:0] in_s [P];
  logic         in_c [P];
  logic         in_v [P];
  logic [N-1:0] nx_s [P];
  logic         nx_c [P];
  logic         nx_m [P];

  logic [SEG:0]   seg_sum;
  logic [SEG-1:0] seg_a;
  logic [SEG-1:0] seg_b;
  logic           en;

  assign en            = ~v_q[P-1] | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v_q[P-1];
  assign bus.c_out     = c_q[P-1];
  assign bus.ovf       = m_q[P-1] ^ c_q[P-1];

`ifdef PIPE_ADDER_SAT_EN
  // Clamp on overflow; both operand signs agree when ovf is set, so A's sign picks the direction
  assign bus.s = bus.ovf ? (a_q[P-1][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                         : s_q[P-1];
`else
  assign bus.s = s_q[P-1];
`endif

  // Stage inputs: ports feed stage 0 (B inverted and seed forced to 1 for subtract), later stages read their predecessor
  always_comb begin
    in_a[0] = bus.a;
    in_b[0] = bus.sub ? ~bus.b : bus.b;
    in_c[0] = bus.sub | bus.c_in;
    in_s[0] = '0;
    in_v[0] = bus.in_valid;
    for (int k = 1; k < P; k++) begin
      in_a[k] = a_q[k-1];
      in_b[k] = b_q[k-1];
      in_c[k] = c_q[k-1];
      in_s[k] = s_q[k-1];
      in_v[k] = v_q[k-1];
    end
  end

  // Segment adders: stage k adds bits k*SEG +: SEG and records the carry into the segment MSB
  always_comb begin
    seg_a   = '0;
    seg_b   = '0;
    seg_sum = '0;
    for (int k = 0; k < P; k++) begin
      seg_a   = in_a[k][k*SEG +: SEG];
      seg_b   = in_b[k][k*SEG +: SEG];
      seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, in_c[k]};
      nx_s[k] = in_s[k];
      nx_s[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      nx_c[k] = seg_sum[SEG];
      nx_m[k] = seg_sum[SEG-1] ^ seg_a[SEG-1] ^ seg_b[SEG-1];
    end
  end

  // Pipeline registers: the whole pipe advances together on en and freezes otherwise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < P; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < P; k++) begin
        a_q[k] <= in_a[k];
        b_q[k] <= in_b[k];
        s_q[k] <= nx_s[k];
        c_q[k] <= nx_c[k];
        m_q[k] <= nx_m[k];
        v_q[k] <= in_v[k];
      end
    end
  end
endmodule
